// File: rtl/debug_reg_dumper.sv
`default_nettype none
// ============================================================================
// Module   : debug_reg_dumper
// Purpose  : Walks the register bank's debug read port, snapshots each word and
//            streams it LSB-first as four bytes to the debug UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module debug_reg_dumper #(
    parameter int DATA_WIDTH = 32,
    parameter int NREGS      = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic [4:0]            o_reg_addr,
    input  logic [DATA_WIDTH-1:0] i_reg_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FETCH = 3'd1;
    localparam logic [2:0] c_S_SEND  = 3'd2;
    localparam logic [2:0] c_S_NEXT  = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    localparam logic [4:0] c_LAST_ADDR = 5'(NREGS - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [1:0]            r_byte_cnt;
    logic [4:0]            r_reg_addr;
    logic                  w_xfer;

    assign w_xfer = (r_state == c_S_SEND) && i_tx_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:  if (i_start) w_next_state = c_S_FETCH;
            c_S_FETCH: w_next_state = c_S_SEND;
            c_S_SEND:  if (w_xfer && (r_byte_cnt == 2'd3)) w_next_state = c_S_NEXT;
            c_S_NEXT:  w_next_state = (r_reg_addr == c_LAST_ADDR) ? c_S_DONE : c_S_FETCH;
            c_S_DONE:  w_next_state = c_S_IDLE;
            default:   w_next_state = c_S_IDLE;
        endcase
    end

    // The word is frozen in FETCH; later bank writes cannot reach the bytes in flight.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shift    <= '0;
            r_byte_cnt <= 2'd0;
            r_reg_addr <= 5'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (i_start) r_reg_addr <= 5'd0;
                end
                c_S_FETCH: begin
                    r_shift    <= i_reg_data;
                    r_byte_cnt <= 2'd0;
                end
                c_S_SEND: begin
                    if (w_xfer && (r_byte_cnt != 2'd3)) begin
                        r_shift    <= r_shift >> 8;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                c_S_NEXT: begin
                    if (r_reg_addr != c_LAST_ADDR) r_reg_addr <= r_reg_addr + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Valid is a pure state decode, so ready never feeds back into it.
    assign o_tx_valid = (r_state == c_S_SEND);
    assign o_tx_data  = r_shift[7:0];
    assign o_reg_addr = r_reg_addr;
    assign o_busy     = (r_state == c_S_FETCH) || (r_state == c_S_SEND) || (r_state == c_S_NEXT);
    assign o_done     = (r_state == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_debug_reg_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_reg_dumper
// Purpose  : Scoreboard bench for debug_reg_dumper: byte stream, timing, stalls,
//            ignored starts, snapshotting and mid-dump reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_reg_dumper;

    localparam int NREGS = 32;

    logic        i_clock;
    logic        i_reset;
    logic        i_start;
    logic [4:0]  o_reg_addr;
    logic [31:0] w_reg_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_done;

    logic [31:0] bank [NREGS];
    logic [7:0]  exp_q [$];

    int vectors     = 0;
    int miscompares = 0;
    int rel         = 0;
    int done_at     = -1;
    int busy_hi     = -1;
    int rst_at_g    = -1;
    bit stall_g     = 0;
    bit mon_en      = 0;

    debug_reg_dumper #(.DATA_WIDTH(32), .NREGS(NREGS)) u_dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .o_reg_addr (o_reg_addr),
        .i_reg_data (w_reg_data),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    assign w_reg_data = bank[o_reg_addr];

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (rel cycle %0d)", tag, obs, exp, rel);
        end
    endtask

    // Outputs are sampled on the falling edge, mid-way between input updates.
    always @(negedge i_clock) begin
        if (mon_en) begin
            if (o_tx_valid && i_tx_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
            end
            check("done", {31'd0, o_done}, {31'd0, (rel == done_at)});
            check("busy", {31'd0, o_busy}, {31'd0, (rel >= 1 && rel <= busy_hi)});
            if (rel == 1) check("first_addr", {27'd0, o_reg_addr}, 32'd0);
            if (stall_g && rel >= 28 && rel <= 32) begin
                check("stall_valid", {31'd0, o_tx_valid}, 32'd1);
                check("stall_data", {24'd0, o_tx_data}, 32'hC3);
            end
            if (rst_at_g >= 0 && rel == rst_at_g + 1)
                check("valid_after_rst", {31'd0, o_tx_valid}, 32'd0);
        end
    end

    task automatic run_dump(input bit stall, input bit busy_pulse, input bit snap, input int rst_at);
        int last;
        logic [31:0] w;
        stall_g  = stall;
        rst_at_g = rst_at;
        done_at  = 6 * NREGS + 1 + (stall ? 5 : 0);
        busy_hi  = done_at - 1;
        if (rst_at >= 0) begin
            done_at = -1;
            busy_hi = rst_at;
        end
        for (int n = 0; n < NREGS; n++) begin
            w = 32'hA5C3_0000 | n;
            for (int b = 0; b < 4; b++) begin
                // Reset lands on reg 7 byte 2 with ready low, so only bytes before it go out.
                if (rst_at < 0 || (n * 4 + b) < (7 * 4 + 2)) exp_q.push_back(w[8*b +: 8]);
            end
        end
        last   = (rst_at >= 0) ? rst_at + 15 : done_at + 4;
        mon_en = 1'b1;
        for (int c = 0; c <= last; c++) begin
            rel        = c;
            i_start    = (c == 0) || (busy_pulse && (c == 10 || c == 100));
            i_tx_ready = !(stall && c >= 28 && c <= 32) && !(rst_at >= 0 && c == rst_at);
            i_reset    = (rst_at >= 0 && c == rst_at);
            if (snap && c == 21) bank[3] = 32'hDEAD_BEEF;
            @(posedge i_clock);
            #1;
        end
        mon_en     = 1'b0;
        i_start    = 1'b0;
        i_reset    = 1'b0;
        i_tx_ready = 1'b1;
        bank[3]    = 32'hA5C3_0003;
        check("sb_empty", exp_q.size(), 32'd0);
        exp_q.delete();
        stall_g  = 1'b0;
        rst_at_g = -1;
    endtask

    initial begin
        for (int n = 0; n < NREGS; n++) bank[n] = 32'hA5C3_0000 | n;
        i_reset    = 1'b1;
        i_start    = 1'b1;
        i_tx_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge i_clock);
            #1;
            check("rst_valid", {31'd0, o_tx_valid}, 32'd0);
            check("rst_busy", {31'd0, o_busy}, 32'd0);
            check("rst_done", {31'd0, o_done}, 32'd0);
            check("rst_addr", {27'd0, o_reg_addr}, 32'd0);
            check("rst_data", {24'd0, o_tx_data}, 32'd0);
        end
        i_reset = 1'b0;
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clock);
            #1;
            check("idle_busy", {31'd0, o_busy}, 32'd0);
            check("idle_valid", {31'd0, o_tx_valid}, 32'd0);
        end

        run_dump(1'b0, 1'b0, 1'b0, -1);   // full dump
        run_dump(1'b1, 1'b0, 1'b0, -1);   // backpressure on reg 4 byte 2
        run_dump(1'b0, 1'b1, 1'b0, -1);   // start pulses while busy
        run_dump(1'b0, 1'b0, 1'b1, -1);   // snapshot of reg 3
        run_dump(1'b0, 1'b0, 1'b0, 46);   // reset during reg 7 byte 2
        run_dump(1'b0, 1'b0, 1'b0, -1);   // restart after reset

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_reg_dumper.md
# debug_reg_dumper

Debug-side reader for the register bank's debug readout port. On a start pulse it walks register indices 0..NREGS-1 and captures each 32-bit value. It then serialises the value as four bytes to the debug UART transmitter over a valid/ready byte stream. It sits between the register bank and the debug UART TX in the MIPS debug unit and supplies the index the bank uses to select its debug output.

## Interface
Parameters:
- DATA_WIDTH, 32, register width; fixed at 32 (four bytes per register).
- NREGS, 32, number of registers dumped; legal range 2..32.

Ports:
- i_clock  in  1  single clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  dump request; sampled only in IDLE.
- o_reg_addr  out  5  register index presented to the bank's debug read port (registered).
- i_reg_data  in  DATA_WIDTH  bank debug read data; combinational function of o_reg_addr, valid in the same cycle.
- o_tx_data  out  8  byte to the UART transmitter.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  transmitter accepts the byte this cycle.
- o_busy  out  1  high from the FETCH of register 0 through the NEXT of the last register.
- o_done  out  1  one-cycle pulse when the dump completes.

## Operation
- State machine: IDLE, FETCH, SEND, NEXT, DONE.
- IDLE:
  - o_busy=0 and o_tx_valid=0.
  - i_start=1 sets o_reg_addr=0 and goes to FETCH.
- FETCH:
  - Capture i_reg_data into a 32-bit shift register and clear byte_cnt.
  - Go to SEND.
- SEND:
  - o_tx_valid=1 and o_tx_data=shift[7:0], so bytes go out LSB first (little-endian).
  - A transfer occurs when o_tx_valid and i_tx_ready are both high.
  - On a transfer with byte_cnt<3: shift right by 8 and increment byte_cnt.
  - On a transfer with byte_cnt==3: go to NEXT.
  - With no transfer, o_tx_data and o_tx_valid hold stable.
- NEXT:
  - If o_reg_addr==NREGS-1, go to DONE.
  - Otherwise increment o_reg_addr and go to FETCH.
- DONE: o_done=1 for exactly one cycle, o_busy=0, then IDLE. o_reg_addr keeps the last index.
- i_start outside IDLE is ignored; there is no queuing.
- Each register is snapshotted in FETCH. Bank writes after that cycle do not alter the bytes already captured.
- Reset values: state=IDLE, o_reg_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, byte_cnt=0, shift register=0.
- Reset mid-operation:
  - Abort immediately. No o_done is produced, and any byte in progress is dropped.
  - o_tx_valid is low in the cycle after the reset edge.
  - i_reset has priority over i_start in the same cycle.

## Timing
- Let cycle 0 be the cycle in which i_start=1 is sampled in IDLE. FETCH of register 0 is cycle 1.
- With i_tx_ready held high, each register takes 6 cycles: FETCH, 4×SEND, NEXT.
- Register n occupies cycles 6n+1 .. 6n+6.
- o_done is high in cycle 6·NREGS+1, which is cycle 193 for NREGS=32.
- o_busy is high in cycles 1 .. 6·NREGS.
- Each low cycle of i_tx_ready during SEND adds exactly one cycle. There is no other stall source.
- o_tx_valid never drops before its transfer completes, and data never changes while valid=1 and ready=0.
- At most one byte transfers per cycle. The first byte is valid in cycle 2.
- Peak throughput is 4 bytes per 6 cycles; there is no combinational path from i_tx_ready to o_tx_valid.

## Test plan
- Reset: assert i_reset for 2 cycles with i_start=1. All outputs must read 0, and the block stays in IDLE after reset releases until a new start.
- Full dump, ready=1, bank reg[n]=32'hA5C3_0000|n:
  - Byte stream must be n, 0x00, 0xC3, 0xA5 for n=0..31, 128 bytes total.
  - o_done must be high only in cycle 193; o_busy must be high in cycles 1..192.
- Backpressure: hold i_tx_ready=0 for 5 cycles on byte 2 of reg 4.
  - o_tx_data must stay 0xC3 with o_tx_valid=1 throughout.
  - o_done must be delayed by exactly 5 cycles, to cycle 198.
- Start while busy: pulse i_start in cycles 10 and 100. The byte stream and the o_done timing must be identical to the full-dump case.
- Snapshot: write reg 3 with 0xDEADBEEF during SEND of reg 3. The bytes sent must still be 0x03, 0x00, 0xC3, 0xA5.
- Reset mid-dump: assert i_reset during SEND of reg 7 byte 2.
  - o_tx_valid must be 0 on the next cycle, and no o_done may follow.
  - A new i_start must restart at o_reg_addr=0 with first byte 0x00.
